// File: rtl/alu_exec_seq.sv
// Multi-cycle RV32I R/I-type executor.
// Walks read -> execute -> writeback against external reg_file / alu_op / alu.
package alu_exec_pkg;
    typedef logic [4:0] regName_t;
    typedef enum logic {TYPE_R = 1'b0, TYPE_I = 1'b1} aluOp_t;
endpackage

module alu_exec_seq
    import alu_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic                  instr_ready,
    output regName_t              rs1,
    output regName_t              rs2,
    input  logic [DATA_WIDTH-1:0] regA_out,
    input  logic [DATA_WIDTH-1:0] regB_out,
    output regName_t              rd,
    output logic                  wen,
    output logic [DATA_WIDTH-1:0] data_in,
    output aluOp_t                aluOp,
    output logic [6:0]            funct7,
    output logic [2:0]            funct3,
    input  logic                  alu_error,
    output logic [DATA_WIDTH-1:0] bus_a,
    output logic [DATA_WIDTH-1:0] bus_b,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [6:0] OP_R = 7'h33;
    localparam logic [6:0] OP_I = 7'h13;

    logic [1:0]            state;
    logic                  is_i_q;
    logic [2:0]            f3_q;
    regName_t              rd_q;
    logic [11:0]           hi_q;
    logic                  err_q;
    logic                  bad_q;

    logic                  legal_op;
    logic                  shift_op;
    logic [DATA_WIDTH-1:0] imm;

    assign legal_op = (instr[6:0] == OP_R) || (instr[6:0] == OP_I);
    assign shift_op = (f3_q == 3'd1) || (f3_q == 3'd5);
    assign imm      = {{(DATA_WIDTH-12){hi_q[11]}}, hi_q};

    assign instr_ready = (state == S_IDLE);
    assign done        = (state == S_WB);
    assign wen         = done && (rd != 5'd0) && !err_q && !bad_q;
    assign illegal     = done && (err_q || bad_q);
    assign data_in     = result;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= S_IDLE;
            rs1    <= '0;
            rs2    <= '0;
            rd     <= '0;
            funct7 <= '0;
            funct3 <= '0;
            aluOp  <= TYPE_R;
            bus_a  <= '0;
            bus_b  <= '0;
            result <= '0;
            is_i_q <= 1'b0;
            f3_q   <= '0;
            rd_q   <= '0;
            hi_q   <= '0;
            err_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        is_i_q <= (instr[6:0] == OP_I);
                        f3_q   <= instr[14:12];
                        rd_q   <= instr[11:7];
                        hi_q   <= instr[31:20];
                        err_q  <= 1'b0;
                        bad_q  <= !legal_op;
                        if (legal_op) begin
                            rs1   <= instr[19:15];
                            rs2   <= instr[24:20];
                            state <= S_READ;
                        end else begin
                            // Bad opcode skips straight to retirement, nothing to compute.
                            rd     <= instr[11:7];
                            result <= '0;
                            state  <= S_WB;
                        end
                    end
                end
                S_READ: begin
                    bus_a  <= regA_out;
                    bus_b  <= is_i_q ? imm : regB_out;
                    funct3 <= f3_q;
                    funct7 <= (!is_i_q || shift_op) ? hi_q[11:5] : 7'd0;
                    aluOp  <= is_i_q ? TYPE_I : TYPE_R;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    result <= alu_out;
                    err_q  <= alu_error;
                    rd     <= rd_q;
                    state  <= S_WB;
                end
                S_WB: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: reg_file/ALU environment, instruction-level
// model checked every cycle, plus directed vectors with literal results.
module tb_alu_exec_seq;
    import alu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] regA_out, regB_out, data_in, bus_a, bus_b, alu_out, result;
    logic        wen, alu_error, done, illegal;
    aluOp_t      aluOp;
    logic [6:0]  funct7;
    logic [2:0]  funct3;

    always #5 clk = ~clk;

    alu_exec_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstN(rstN),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .rs1(rs1), .rs2(rs2), .regA_out(regA_out), .regB_out(regB_out),
        .rd(rd), .wen(wen), .data_in(data_in),
        .aluOp(aluOp), .funct7(funct7), .funct3(funct3), .alu_error(alu_error),
        .bus_a(bus_a), .bus_b(bus_b), .alu_out(alu_out),
        .done(done), .result(result), .illegal(illegal)
    );

    // reg_file stand-in
    logic [31:0] rf [32] = '{default: 32'd0};
    logic        pl_en = 1'b0;
    logic [4:0]  pl_a = 5'd0;
    logic [31:0] pl_d = 32'd0;

    always @(posedge clk) begin
        if (pl_en) rf[pl_a] <= pl_d;
        else if (wen) rf[rd] <= data_in;
    end
    assign regA_out = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign regB_out = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    // alu_op + alu stand-in, driven from the decoded fields
    function automatic logic [32:0] alu_env(input aluOp_t op, input logic [2:0] f3,
                                            input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        logic        e;
        logic        alt;
        alt = (f7 == 7'h20);
        e   = 1'b0;
        if (f7 != 7'h00 && !alt) e = 1'b1;
        if (alt && f3 != 3'd5 && !(f3 == 3'd0 && op == TYPE_R)) e = 1'b1;
        if (op == TYPE_I && f7 != 7'h00 && f3 != 3'd5) e = 1'b1;
        case (f3)
            3'd0: y = (alt && op == TYPE_R) ? a - b : a + b;
            3'd1: y = a << b[4:0];
            3'd2: y = {31'd0, $signed(a) < $signed(b)};
            3'd3: y = {31'd0, a < b};
            3'd4: y = a ^ b;
            3'd5: y = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: y = a | b;
            default: y = a & b;
        endcase
        return {e, y};
    endfunction

    always_comb {alu_error, alu_out} = alu_env(aluOp, funct3, funct7, bus_a, bus_b);

    // Instruction-level model: {error, value} from the raw word and operands
    function automatic logic [32:0] model(input logic [31:0] ins,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] src;
        logic        is_i, hi, e;
        logic [31:0] y;
        f7   = ins[31:25];
        f3   = ins[14:12];
        is_i = (ins[6:0] == 7'h13);
        src  = is_i ? {{20{ins[31]}}, ins[31:20]} : b;
        hi   = (f7 == 7'h20);
        if (!is_i)           e = !(f7 == 7'h00 || (hi && (f3 == 3'd0 || f3 == 3'd5)));
        else if (f3 == 3'd1) e = (f7 != 7'h00);
        else if (f3 == 3'd5) e = !(f7 == 7'h00 || hi);
        else                 e = 1'b0;
        case (f3)
            3'd0: y = (!is_i && hi) ? a - src : a + src;
            3'd1: y = a << src[4:0];
            3'd2: y = ($signed(a) < $signed(src)) ? 32'd1 : 32'd0;
            3'd3: y = (a < src) ? 32'd1 : 32'd0;
            3'd4: y = a ^ src;
            3'd5: y = hi ? 32'($signed(a) >>> src[4:0]) : a >> src[4:0];
            3'd6: y = a | src;
            default: y = a & src;
        endcase
        return {e, y};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic expired(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired t=%0t", nm, $time);
    endtask

    // Compare process state
    logic [31:0] gold [32] = '{default: 32'd0};
    bit          active = 1'b0;
    bit          was_idle, edone, ewen, bad, eill, eerr;
    int          ph = 0, lat = 0, dut_lat = -1, cyc = 0;
    int          retired = 0, wen_cnt = 0, last_lat = 0;
    int          acc_q [$];
    logic [31:0] cur, exp_res, ea, eb, last_res, last_busb;
    logic [6:0]  ef7, last_f7;
    logic        last_ill;

    always @(negedge clk) begin
        cyc++;
        if (pl_en) gold[pl_a] = pl_d;
        if (!rstN) begin
            active = 1'b0;
            chk("rst_done", done, 0);
            chk("rst_wen", wen, 0);
            chk("rst_ready", instr_ready, 1);
        end else begin
            was_idle = !active;
            if (active) begin
                ph++;
                if (!bad && ph == 1) begin
                    chk("rs1", rs1, cur[19:15]);
                    chk("rs2", rs2, cur[24:20]);
                end
                if (!bad && ph == 2) begin
                    chk("bus_a", bus_a, ea);
                    chk("bus_b", bus_b, eb);
                    chk("funct3", funct3, cur[14:12]);
                    chk("funct7", funct7, ef7);
                    chk("aluOp", aluOp, (cur[6:0] == 7'h13) ? 1 : 0);
                    last_busb = bus_b;
                    last_f7   = funct7;
                end
                if (done && dut_lat < 0) dut_lat = ph;
            end
            if (wen) wen_cnt++;
            edone = active && (ph == lat);
            ewen  = edone && (cur[11:7] != 5'd0) && !eill;
            chk("done", done, edone);
            chk("ready", instr_ready, was_idle);
            chk("wen", wen, ewen);
            if (edone) begin
                chk("illegal", illegal, eill);
                chk("rd", rd, cur[11:7]);
                if (!eill) chk("result", result, exp_res);
                if (ewen) begin
                    chk("data_in", data_in, exp_res);
                    gold[cur[11:7]] = exp_res;
                end
                last_res = result;
                last_ill = illegal;
                last_lat = dut_lat;
                retired++;
                active = 1'b0;
            end
            if (was_idle && instr_valid) begin
                active  = 1'b1;
                ph      = 0;
                dut_lat = -1;
                cur     = instr;
                bad     = !(instr[6:0] == 7'h33 || instr[6:0] == 7'h13);
                lat     = bad ? 1 : 3;
                ea      = gold[instr[19:15]];
                eb      = (instr[6:0] == 7'h13) ? {{20{instr[31]}}, instr[31:20]}
                                                 : gold[instr[24:20]];
                ef7     = (instr[6:0] == 7'h13 && instr[14:12] != 3'd1 &&
                           instr[14:12] != 3'd5) ? 7'd0 : instr[31:25];
                {eerr, exp_res} = model(instr, gold[instr[19:15]], gold[instr[24:20]]);
                eill    = bad || eerr;
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (instr_ready) begin ok = 1'b1; break; end
        end
        if (!ok) expired(nm);
    endtask

    task automatic wait_retired(input int target, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (retired >= target) begin ok = 1'b1; break; end
        end
        if (!ok) expired(nm);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [31:0] ins);
        int r0;
        r0 = retired;
        @(posedge clk); #1;
        instr = ins; instr_valid = 1'b1;
        wait_ready("accept");
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wait_retired(r0 + 1, "retire");
    endtask

    logic [31:0] b2b [3] = '{32'h00B50633, 32'h40A586B3, 32'h06460713};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int w0, n0, n;
        rstN = 1'b0; instr_valid = 1'b0; instr = 32'd0;

        // Pin the model against hand-computed values
        chk("m_add", model(32'h00B502B3, 32'd5, 32'd7), {1'b0, 32'd12});
        chk("m_sub", model(32'h40A903B3, 32'd3, 32'd5), {1'b0, 32'hFFFFFFFE});
        chk("m_srai", model(32'h40435313, 32'hFFFFFFFF, 32'd0), {1'b0, 32'hFFFFFFFF});
        chk("m_mul_err", model(32'h02B502B3, 32'd5, 32'd7) >> 32, 33'd1);

        repeat (3) @(negedge clk);
        chk("rst_rs1", rs1, 0);
        chk("rst_rs2", rs2, 0);
        chk("rst_rd", rd, 0);
        chk("rst_aluOp", aluOp, TYPE_R);
        chk("rst_f7f3", {funct7, funct3}, 0);
        chk("rst_bus", {bus_a | bus_b}, 0);
        chk("rst_result", result, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk); #1;
        rstN = 1'b1;

        preload(5'd10, 32'd5);
        preload(5'd11, 32'd7);
        preload(5'd18, 32'd3);

        // add x5,x10,x11
        w0 = wen_cnt;
        run(32'h00B502B3);
        chk("t1_result", last_res, 12);
        chk("t1_latency", last_lat, 3);
        chk("t1_wen_pulses", wen_cnt - w0, 1);
        chk("t1_x5", rf[5], 12);

        // sub x7,x18,x10
        run(32'h40A903B3);
        chk("t2_result", last_res, 32'hFFFFFFFE);
        chk("t2_x7", rf[7], 32'hFFFFFFFE);

        // addi x6,x0,-1 ; srai x6,x6,4
        run(32'hFFF00313);
        chk("t3_bus_b", last_busb, 32'hFFFFFFFF);
        chk("t3_addi", last_res, 32'hFFFFFFFF);
        run(32'h40435313);
        chk("t3_srai_f7", last_f7, 7'h20);
        chk("t3_srai", last_res, 32'hFFFFFFFF);

        // ori x8,x10,-16: immediate high bits must not reach funct7
        run(32'hFF056413);
        chk("t3_ori_f7", last_f7, 0);
        chk("t3_ori", last_res, 32'hFFFFFFF5);
        chk("t3_ori_ill", last_ill, 0);

        // add x0,x10,x11
        w0 = wen_cnt;
        run(32'h00B50033);
        chk("t4_x0_result", last_res, 12);
        chk("t4_x0_ill", last_ill, 0);
        chk("t4_x0_wen", wen_cnt - w0, 0);

        // lw opcode: illegal, short path
        w0 = wen_cnt;
        run(32'h00052283);
        chk("t4_op03_ill", last_ill, 1);
        chk("t4_op03_lat", last_lat, 1);
        chk("t4_op03_wen", wen_cnt - w0, 0);

        // funct7=1 (mul): alu error, full latency, no write
        w0 = wen_cnt;
        run(32'h02B502B3);
        chk("t4_aluerr_ill", last_ill, 1);
        chk("t4_aluerr_lat", last_lat, 3);
        chk("t4_aluerr_wen", wen_cnt - w0, 0);
        chk("t4_aluerr_x5", rf[5], 12);

        // Back-to-back with instr_valid held
        n0 = acc_q.size();
        w0 = retired;
        @(posedge clk); #1;
        instr = b2b[0]; instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready("b2b_accept");
            @(posedge clk); #1;
            if (i < 2) instr = b2b[i+1];
            else instr_valid = 1'b0;
        end
        wait_retired(w0 + 3, "b2b_retire");
        n = acc_q.size();
        chk("t5_accepts", n - n0, 3);
        if (n - n0 >= 3) begin
            chk("t5_space1", acc_q[n-2] - acc_q[n-3], 4);
            chk("t5_space2", acc_q[n-1] - acc_q[n-2], 4);
        end
        chk("t5_x12", rf[12], 12);
        chk("t5_x13", rf[13], 2);
        chk("t5_x14", rf[14], 112);

        // Reset asserted while in EXEC
        @(posedge clk); #1;
        instr = 32'h00B504B3; instr_valid = 1'b1;
        wait_ready("rst_accept");
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        chk("t6_wen_async", wen, 0);
        chk("t6_done_async", done, 0);
        @(posedge clk); @(posedge clk); #1;
        rstN = 1'b1;
        chk("t6_ready", instr_ready, 1);
        @(posedge clk); #1;
        chk("t6_x9_dropped", rf[9], 0);
        run(32'h00B504B3);
        chk("t6_result", last_res, 12);
        chk("t6_x9", rf[9], 12);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
